// File: rtl/util_fifo_pkg.sv
// Shared constants and helpers for the parametrised utility FIFO.
package util_fifo_pkg;

  localparam int UTIL_FIFO_DATA_W = 64;
  localparam int UTIL_FIFO_DEPTH  = 16;

  // Occupancy needs one bit more than the pointers to represent DEPTH itself.
  function automatic int fifo_count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/util_fifo_ram.sv
// Simple dual-port register array: synchronous write, synchronous (registered) read.
module util_fifo_ram
  import util_fifo_pkg::*;
#(
  parameter  int DATA_W = UTIL_FIFO_DATA_W,
  parameter  int DEPTH  = UTIL_FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // NOTE: the storage array is deliberately left without reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/util_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, threshold flags and sticky errors.
// Define UTIL_FIFO_FWFT_EN for first-word fall-through output; default is registered read.
module util_fifo_param
  import util_fifo_pkg::*;
#(
  parameter  int DATA_W    = UTIL_FIFO_DATA_W,
  parameter  int DEPTH     = UTIL_FIFO_DEPTH,
  parameter  int AF_THRESH = DEPTH - 2,
  parameter  int AE_THRESH = 2,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  input  logic              err_clr,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int CNT_W = fifo_count_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);

  logic              wr_acc, rd_acc;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              af_q, af_d, ae_q, ae_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rd_acc   = rd_en & ~empty_q;
    wr_acc   = wr_en & (~full_q | rd_acc);
    wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Flags follow next-count so they line up with count in the same cycle.
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_CNT);
    ae_d    = (count_d <= AE_CNT);

    // Set wins over clear when both happen in one cycle.
    ovf_d = (wr_en & ~wr_acc) | (ovf_q & ~err_clr);
    udf_d = (rd_en & empty_q) | (udf_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

`ifdef UTIL_FIFO_FWFT_EN
  // The RAM prefetches the next head; a word written straight into the head slot bypasses it.
  logic              byp_load;
  logic              byp_sel_q, byp_sel_d;
  logic [DATA_W-1:0] byp_q, byp_d;

  always_comb begin
    byp_load  = wr_acc && (wr_ptr_q == rd_ptr_d);
    ram_re    = (count_d != '0) && !byp_load;
    byp_d     = byp_load ? din : byp_q;
    byp_sel_d = byp_sel_q;
    if (byp_load)    byp_sel_d = 1'b1;
    else if (ram_re) byp_sel_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byp_q     <= '0;
      byp_sel_q <= 1'b0;
    end else begin
      byp_q     <= byp_d;
      byp_sel_q <= byp_sel_d;
    end
  end

  assign ram_raddr = rd_ptr_d;
  assign dout      = byp_sel_q ? byp_q : ram_rdata;
`else
  assign ram_re    = rd_acc;
  assign ram_raddr = rd_ptr_q;
  assign dout      = ram_rdata;
`endif

  util_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (din),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_util_fifo_param.sv
// Directed self-checking bench for util_fifo_param (default 64x16; honours UTIL_FIFO_FWFT_EN).
module tb_util_fifo_param;

  logic        clk = 1'b0;
  logic        reset, wr_en, rd_en, err_clr;
  logic [63:0] din, dout;
  logic        full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]  count;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  util_fifo_param dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .err_clr      (err_clr),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d);
    wr_en = 1'b1; din = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Returns the word a pop delivers, in whichever output mode is built.
  task automatic pop(output logic [63:0] d);
`ifdef UTIL_FIFO_FWFT_EN
    d = dout;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
`else
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    d = dout;
`endif
  endtask

  task automatic clear_errors();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = '0;
    tick(); tick();
    reset = 1'b0;
    n_tests++;
    if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++;
    if (dout !== 64'd0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", dout); end
    n_tests++;
    if ({empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 101000",
               {empty, full, almost_empty, almost_full, overflow, underflow});
    end
  endtask

  task automatic test_empty_read();
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({empty, count, underflow} !== {1'b1, 5'd0, 1'b1} || dout !== 64'd0) begin
        n_fail++;
        $display("FAIL empty_read[%0d]: empty=%b count=%0d underflow=%b dout=%h want 1/0/1/0",
                 i, empty, count, underflow, dout);
      end
    end
    rd_en = 1'b0;
    clear_errors();
    n_tests++;
    if (underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_clear: got %b want 0", underflow); end
  endtask

  task automatic test_fill_overflow_drain();
    logic [63:0] d;
    logic [3:0]  exp_flags;
    for (int i = 0; i < 16; i++) begin
      push(64'(i));
      exp_flags = {(i + 1 == 16), (i + 1 >= 14), (i + 1 <= 2), 1'b0};
      n_tests++;
      if (count !== 5'(i + 1) || {full, almost_full, almost_empty, empty} !== exp_flags) begin
        n_fail++;
        $display("FAIL fill[%0d]: count=%0d flags(f,af,ae,e)=%b want %0d/%b",
                 i, count, {full, almost_full, almost_empty, empty}, i + 1, exp_flags);
      end
    end
    push(64'hDEAD);
    n_tests++;
    if ({overflow, full, count} !== {1'b1, 1'b1, 5'd16}) begin
      n_fail++;
      $display("FAIL overflow: ovf=%b full=%b count=%0d want 1/1/16", overflow, full, count);
    end
    for (int i = 0; i < 16; i++) begin
      pop(d);
      n_tests++;
      if (d !== 64'(i) || count !== 5'(15 - i)) begin
        n_fail++;
        $display("FAIL drain[%0d]: dout=%h count=%0d want %h/%0d", i, d, count, 64'(i), 15 - i);
      end
    end
    n_tests++;
    if ({empty, almost_empty, overflow} !== 3'b111) begin
      n_fail++;
      $display("FAIL drained_flags: e/ae/ovf=%b want 111", {empty, almost_empty, overflow});
    end
    clear_errors();
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_clear: got %b want 0", overflow); end
  endtask

  task automatic test_simul_full();
    logic [63:0] d;
    for (int i = 0; i < 16; i++) push(64'(i));
    wr_en = 1'b1; rd_en = 1'b1; din = 64'hAA;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    n_tests++;
    if ({count, full, overflow} !== {5'd16, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL simul_full: count=%0d full=%b ovf=%b want 16/1/0", count, full, overflow);
    end
    n_tests++;
`ifdef UTIL_FIFO_FWFT_EN
    if (dout !== 64'd1) begin n_fail++; $display("FAIL simul_full_dout: got %h want 1", dout); end
`else
    if (dout !== 64'd0) begin n_fail++; $display("FAIL simul_full_dout: got %h want 0", dout); end
`endif
    for (int i = 1; i <= 16; i++) begin
      pop(d);
      n_tests++;
      if (d !== ((i == 16) ? 64'hAA : 64'(i))) begin
        n_fail++;
        $display("FAIL simul_full_drain[%0d]: got %h want %h", i, d, (i == 16) ? 64'hAA : 64'(i));
      end
    end
    n_tests++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL simul_full_empty: got %b want 1", empty); end
  endtask

  task automatic test_simul_empty();
    logic [63:0] d;
    wr_en = 1'b1; rd_en = 1'b1; din = 64'h55;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    n_tests++;
    if ({count, underflow, empty} !== {5'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL simul_empty: count=%0d udf=%b empty=%b want 1/1/0", count, underflow, empty);
    end
    n_tests++;
`ifdef UTIL_FIFO_FWFT_EN
    if (dout !== 64'h55) begin n_fail++; $display("FAIL simul_empty_dout: got %h want 55", dout); end
`else
    if (dout !== 64'hAA) begin n_fail++; $display("FAIL simul_empty_hold: got %h want aa", dout); end
`endif
    pop(d);
    n_tests++;
    if (d !== 64'h55 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL simul_empty_read: dout=%h count=%0d want 55/0", d, count);
    end
    clear_errors();
  endtask

  task automatic test_wrap();
    logic [63:0] q[$];
    logic [63:0] dout_exp = 64'h55;
    logic [63:0] wd;
    logic        we, re, m_wr, m_rd;
    for (int i = 0; i < 40; i++) begin
      we = ($urandom_range(0, 7) != 0);
      re = ($urandom_range(0, 3) != 0);
      wd = {$urandom, $urandom};
      m_rd = re && (q.size() > 0);
      m_wr = we && (q.size() < 16 || m_rd);
      wr_en = we; rd_en = re; din = wd;
      tick();
`ifdef UTIL_FIFO_FWFT_EN
      if (m_rd) void'(q.pop_front());
      if (m_wr) q.push_back(wd);
      if (q.size() > 0) dout_exp = q[0];
`else
      if (m_rd) dout_exp = q.pop_front();
      if (m_wr) q.push_back(wd);
`endif
      n_tests++;
      if (count !== 5'(q.size()) || dout !== dout_exp) begin
        n_fail++;
        $display("FAIL wrap[%0d]: count=%0d dout=%h want %0d/%h", i, count, dout, q.size(), dout_exp);
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    for (int i = 0; i < 5; i++) push(64'h100 + 64'(i));
    reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = 64'h99;
    tick();
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    n_tests++;
    if (count !== 5'd0 || dout !== 64'd0 ||
        {empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000) begin
      n_fail++;
      $display("FAIL reset_mid: count=%0d dout=%h flags=%b want 0/0/101000", count, dout,
               {empty, full, almost_empty, almost_full, overflow, underflow});
    end
    push(64'h77);
    n_tests++;
`ifdef UTIL_FIFO_FWFT_EN
    if (dout !== 64'h77 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL fwft_fallthrough: dout=%h empty=%b want 77/0", dout, empty);
    end
`else
    if (dout !== 64'd0 || empty !== 1'b0 || count !== 5'd1) begin
      n_fail++;
      $display("FAIL post_reset_write: dout=%h empty=%b count=%0d want 0/0/1", dout, empty, count);
    end
`endif
    pop(d);
    n_tests++;
    if (d !== 64'h77 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_read: dout=%h empty=%b want 77/1", d, empty);
    end
  endtask

  initial begin
    test_reset();
    test_empty_read();
    test_fill_overflow_drain();
    test_simul_full();
    test_simul_empty();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
